// File: rtl/pool_window_fetch.sv
// Window fetcher for the pooling engine: stores a CH x H x W activation map and returns
// a packed CH_PAR-channel 2x2 window per request. Optional macro: POOL_FETCH_ZERO_PAD_EN.
module pool_window_fetch #(
  parameter int DATA_W = 16,
  parameter int CH     = 8,
  parameter int H      = 16,
  parameter int W      = 16,
  parameter int CH_PAR = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  output logic                       wr_ready,
  input  logic [7:0]                 wr_ch,
  input  logic [7:0]                 wr_h,
  input  logic [7:0]                 wr_w,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [7:0]                 channel_sel,
  input  logic [7:0]                 inh,
  input  logic [7:0]                 inw,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W*CH_PAR*4-1:0] infeature_block,
  output logic [1:0]                 state_dbg
);
  localparam int N_LANES = CH_PAR * 4;
  localparam int CW      = $clog2(CH);
  localparam int HW      = $clog2(H);
  localparam int WW      = $clog2(W);
  localparam int AW      = CW + HW + WW;
  localparam int DEPTH   = CH * H * W;
  localparam int LW      = $clog2(N_LANES);
  localparam int CNTW    = $clog2(N_LANES + 2);
  // FETCH spends one cycle per lane plus two cycles draining the read pipeline.
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(N_LANES + 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; a raised
  // rsp_valid and its data stay unchanged until rsp_ready is seen.
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RESP = 2'd2} state_t;

  state_t            state, state_next;
  logic [CNTW-1:0]   cnt;
  logic [7:0]        ch_q, h_q, w_q;
  logic [8:0]        ch_sum, h_sum, w_sum;
  logic              lane_pad, issue, rd_en, wr_fire;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic              rd_vld, rd_zero;
  logic [LW-1:0]     rd_lane;

  assign state_dbg = state;

  // Lane n = i*4 + j*2 + k maps directly onto the fetch counter bits.
  assign ch_sum = {1'b0, ch_q} + 9'(cnt >> 2);
  assign h_sum  = {1'b0, h_q} + 9'(cnt[1]);
  assign w_sum  = {1'b0, w_q} + 9'(cnt[0]);

`ifdef POOL_FETCH_ZERO_PAD_EN
  assign lane_pad = (ch_sum >= 9'(CH)) || (h_sum >= 9'(H)) || (w_sum >= 9'(W));
`else
  logic unused_sum_bits;
  assign unused_sum_bits = ^{ch_sum[8:CW], h_sum[8:HW], w_sum[8:WW]};
  assign lane_pad = 1'b0;
`endif

  assign rd_addr = {ch_sum[CW-1:0], h_sum[HW-1:0], w_sum[WW-1:0]};
  assign issue   = (state == FETCH) && (cnt < CNTW'(N_LANES));
  assign rd_en   = issue && !lane_pad;

  assign wr_addr = {wr_ch[CW-1:0], wr_h[HW-1:0], wr_w[WW-1:0]};
  assign wr_fire = wr_en && wr_ready && ({1'b0, wr_ch} < 9'(CH)) &&
                   ({1'b0, wr_h} < 9'(H)) && ({1'b0, wr_w} < 9'(W));

  // Storage is not reset; a same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= wr_data;
    if (rd_en)   rd_data      <= mem[rd_addr];
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    wr_ready   = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = FETCH;
      end
      FETCH: begin
        wr_ready = 1'b0;
        if (cnt == LAST_CNT) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      ch_q            <= '0;
      h_q             <= '0;
      w_q             <= '0;
      rd_vld          <= 1'b0;
      rd_zero         <= 1'b0;
      rd_lane         <= '0;
      infeature_block <= '0;
    end else begin
      state   <= state_next;
      rd_vld  <= issue;
      rd_zero <= lane_pad;
      rd_lane <= cnt[LW-1:0];
      if (state == IDLE && req_valid) begin
        ch_q            <= channel_sel;
        h_q             <= inh;
        w_q             <= inw;
        cnt             <= '0;
        infeature_block <= '0;
      end else begin
        if (state == FETCH) cnt <= cnt + 1'b1;
        for (int n = 0; n < N_LANES; n++) begin
          if (rd_vld && rd_lane == LW'(n))
            infeature_block[n*DATA_W +: DATA_W] <= rd_zero ? '0 : rd_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_pool_window_fetch.sv
// Self-checking bench for pool_window_fetch: directed test-plan steps followed by
// random writes/requests compared against an array model of the feature map.
module tb_pool_window_fetch;
  localparam int DATA_W = 16;
  localparam int CH     = 8;
  localparam int H      = 16;
  localparam int W      = 16;
  localparam int CH_PAR = 4;
  localparam int BW     = DATA_W * CH_PAR * 4;

  logic              clk, rst_n;
  logic              wr_en, wr_ready;
  logic [7:0]        wr_ch, wr_h, wr_w;
  logic [DATA_W-1:0] wr_data;
  logic              req_valid, req_ready;
  logic [7:0]        channel_sel, inh, inw;
  logic              rsp_valid, rsp_ready;
  logic [BW-1:0]     infeature_block;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] model [CH*H*W];
  logic [BW-1:0]     last_blk;

  pool_window_fetch #(.DATA_W(DATA_W), .CH(CH), .H(H), .W(W), .CH_PAR(CH_PAR)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_h(wr_h), .wr_w(wr_w),
    .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .channel_sel(channel_sel), .inh(inh), .inw(inw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .infeature_block(infeature_block), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference window: lane n = i*4+j*2+k holds map[c+i][h+j][w+k].
  function automatic logic [BW-1:0] exp_win(input int c, input int h, input int w);
    logic [BW-1:0] r;
    int cc, hh, ww, n;
    r = '0;
    for (int i = 0; i < CH_PAR; i++)
      for (int j = 0; j < 2; j++)
        for (int k = 0; k < 2; k++) begin
          n = i*4 + j*2 + k;
          cc = c + i; hh = h + j; ww = w + k;
`ifdef POOL_FETCH_ZERO_PAD_EN
          if (cc < CH && hh < H && ww < W)
            r[n*DATA_W +: DATA_W] = model[(cc*H + hh)*W + ww];
`else
          r[n*DATA_W +: DATA_W] = model[((cc % CH)*H + (hh % H))*W + (ww % W)];
`endif
        end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] lane(input logic [BW-1:0] b, input int n);
    return b[n*DATA_W +: DATA_W];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic wr_idle(input int c, input int h, input int w, input logic [DATA_W-1:0] d);
    chk("wr_ready_idle", wr_ready, 1'b1);
    wr_en = 1'b1; wr_ch = 8'(c); wr_h = 8'(h); wr_w = 8'(w); wr_data = d;
    tick;
    wr_en = 1'b0;
    if (c < CH && h < H && w < W) model[(c*H + h)*W + w] = d;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
  endtask

  task automatic finish_rsp;
    rsp_ready = 1'b1;
    tick;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("req_ready_back", req_ready, 1'b1);
    rsp_ready = 1'b0;
  endtask

  // Issues a request, checks latency and window, leaves the block in RESP.
  task automatic req_open(input string tag, input int c, input int h, input int w);
    int lat;
    chk({tag, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; channel_sel = 8'(c); inh = 8'(h); inw = 8'(w);
    tick;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk({tag, "_latency"}, lat, 18);
    chk({tag, "_window"}, infeature_block, exp_win(c, h, w));
    last_blk = infeature_block;
  endtask

  initial begin
    int lat, seen;
    int rc, rh, rw;
    logic [DATA_W-1:0] rd;
    rst_n = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_h = '0; wr_w = '0; wr_data = '0;
    req_valid = 1'b0; channel_sel = '0; inh = '0; inw = '0; rsp_ready = 1'b0;
    #12;
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_wr_ready", wr_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_block", infeature_block, '0);
    rst_n = 1'b1;
    tick;

    // load map[c][h][w] = c*256 + h*16 + w
    for (int c = 0; c < CH; c++)
      for (int h = 0; h < H; h++)
        for (int w = 0; w < W; w++) begin
          wr_en = 1'b1; wr_ch = 8'(c); wr_h = 8'(h); wr_w = 8'(w);
          wr_data = DATA_W'(c*256 + h*16 + w);
          model[(c*H + h)*W + w] = DATA_W'(c*256 + h*16 + w);
          tick;
        end
    wr_en = 1'b0;

    req_open("w000", 0, 0, 0);
    chk("w000_lane0", lane(last_blk, 0), 16'h000);
    chk("w000_lane1", lane(last_blk, 1), 16'h001);
    chk("w000_lane2", lane(last_blk, 2), 16'h010);
    chk("w000_lane3", lane(last_blk, 3), 16'h011);
    chk("w000_lane12", lane(last_blk, 12), 16'h300);
    finish_rsp;

    req_open("w4ee", 4, 14, 14);
    chk("w4ee_lane0", lane(last_blk, 0), 16'h4EE);
    chk("w4ee_lane3", lane(last_blk, 3), 16'h4FF);
    chk("w4ee_lane15", lane(last_blk, 15), 16'h7FF);
    finish_rsp;

    req_open("edge", 6, 15, 15);
`ifdef POOL_FETCH_ZERO_PAD_EN
    chk("edge_lane0", lane(last_blk, 0), 16'h6FF);
    for (int n = 1; n < 4; n++) chk("edge_pad_j_k", lane(last_blk, n), 16'h0);
    for (int n = 8; n < 16; n++) chk("edge_pad_ch", lane(last_blk, n), 16'h0);
`else
    chk("edge_lane1", lane(last_blk, 1), 16'h6F0);
    chk("edge_lane2", lane(last_blk, 2), 16'h60F);
    chk("edge_lane3", lane(last_blk, 3), 16'h600);
    chk("edge_lane8", lane(last_blk, 8), 16'h0FF);
`endif
    finish_rsp;

    // hold RESP with rsp_ready low; a request pulse must be ignored
    req_open("hold", 1, 2, 3);
    for (int t = 0; t < 10; t++) begin
      if (t == 4) begin
        req_valid = 1'b1; channel_sel = 8'd7; inh = 8'd7; inw = 8'd7;
      end else begin
        req_valid = 1'b0;
      end
      tick;
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_data", infeature_block, exp_win(1, 2, 3));
    end
    req_valid = 1'b0;
    finish_rsp;
    req_open("after_hold", 5, 3, 9);
    finish_rsp;

    // write during FETCH is dropped
    req_valid = 1'b1; channel_sel = 8'd2; inh = 8'd0; inw = 8'd0;
    tick;
    req_valid = 1'b0;
    tick; tick;
    wr_en = 1'b1; wr_ch = 8'd0; wr_h = 8'd0; wr_w = 8'd0; wr_data = 16'hBEEF;
    chk("fetch_wr_ready", wr_ready, 1'b0);
    tick;
    wr_en = 1'b0;
    wait_rsp(lat);
    chk("fetch_wr_window", infeature_block, exp_win(2, 0, 0));
    finish_rsp;
    req_open("dropped_wr", 0, 0, 0);
    chk("dropped_wr_lane0", lane(last_blk, 0), 16'h000);
    finish_rsp;
    wr_idle(0, 0, 0, 16'hBEEF);
    req_open("idle_wr", 0, 0, 0);
    chk("idle_wr_lane0", lane(last_blk, 0), 16'hBEEF);
    finish_rsp;

    // reset in the middle of FETCH
    req_valid = 1'b1; channel_sel = 8'd3; inh = 8'd1; inw = 8'd1;
    tick;
    req_valid = 1'b0;
    repeat (8) tick;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_block", infeature_block, '0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_wr_ready", wr_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int t = 0; t < 30; t++) begin
      tick;
      if (rsp_valid !== 1'b0) seen++;
    end
    chk("midrst_no_rsp", seen, 0);

    // random writes (some out of range) and random windows
    for (int it = 0; it < 25; it++) begin
      for (int q = 0; q < 3; q++) begin
        rc = $urandom_range(0, CH + 1);
        rh = $urandom_range(0, H + 1);
        rw = $urandom_range(0, W + 1);
        rd = DATA_W'($urandom);
        wr_idle(rc, rh, rw, rd);
      end
      req_open("rand", $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick;
      chk("rand_hold_valid", rsp_valid, 1'b1);
      finish_rsp;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
